// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexes two 7-seg patterns onto one shared
// active-low segment bus with active-low anodes and blanking gaps.
// Frame: LATCH -> TENS -> GAP1 -> ONES -> GAP2 -> LATCH.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank the tens digit when it shows 0).
module seven_segment_scanner #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] tens_digit,
  input  logic [6:0] ones_digit,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_done
);

  localparam int MAXD = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int TW   = $clog2(MAXD + 1);
  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
  // With no gap the GAP states are unreachable; keep the constant in range anyway.
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (BLANK_CYCLES > 0);

  typedef enum logic [2:0] {S_LATCH, S_TENS, S_GAP1, S_ONES, S_GAP2} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [6:0]      tens_q, tens_d, ones_q, ones_d;
  logic [6:0]      seg_d;
  logic [1:0]      an_d;
  logic            fd_d;

  // Next state, timer and latched patterns; disable parks the scanner in LATCH.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + TW'(1);
    tens_d  = tens_q;
    ones_d  = ones_q;
    if (!enable) begin
      state_d = S_LATCH;
      timer_d = '0;
    end else begin
      case (state_q)
        S_LATCH: begin
          tens_d  = tens_digit;
          ones_d  = ones_digit;
          state_d = S_TENS;
          timer_d = '0;
        end
        S_TENS: if (timer_q == DWELL_LAST) begin
          state_d = HAS_GAP ? S_GAP1 : S_ONES;
          timer_d = '0;
        end
        S_GAP1: if (timer_q == BLANK_LAST) begin
          state_d = S_ONES;
          timer_d = '0;
        end
        S_ONES: if (timer_q == DWELL_LAST) begin
          state_d = HAS_GAP ? S_GAP2 : S_LATCH;
          timer_d = '0;
        end
        S_GAP2: if (timer_q == BLANK_LAST) begin
          state_d = S_LATCH;
          timer_d = '0;
        end
        default: begin
          state_d = S_LATCH;
          timer_d = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so the registered value lines up
  // with the cycle that state is occupied.
  always_comb begin
    seg_d = 7'h7F;
    an_d  = 2'b11;
    fd_d  = 1'b0;
    case (state_d)
      S_TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (tens_d != 7'b0111111) begin
          an_d  = 2'b01;
          seg_d = ~tens_d;
        end
`else
        an_d  = 2'b01;
        seg_d = ~tens_d;
`endif
      end
      S_ONES: begin
        an_d  = 2'b10;
        seg_d = ~ones_d;
      end
      default: ;
    endcase
    if (HAS_GAP)
      fd_d = (state_d == S_GAP2) && (timer_d == BLANK_LAST);
    else
      fd_d = (state_d == S_ONES) && (timer_d == DWELL_LAST);
  end

  // State, timer, latched patterns and registered outputs; reset goes dark at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_LATCH;
      timer_q    <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      seg_n      <= 7'h7F;
      an_n       <= 2'b11;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      seg_n      <= seg_d;
      an_n       <= an_d;
      frame_done <= fd_d;
    end
  end

endmodule
